// File: rtl/reduce_sched_pkg.sv
// reduce_sched_pkg: shared types and constants for the reduction scheduler.
// Holds the FSM state enum, param field bounds and the default timeout.
package reduce_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam int DIMS_MSB = 31;
    localparam int DIMS_LSB = 16;
    localparam int AXES_MSB = 15;
    localparam int AXES_LSB = 0;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/reduce_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr.
// Returns a one-hot grant, its encoded index and an any-valid flag.
module rr_arbiter
    import reduce_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                idx      = IW'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reduce_sched.sv
// reduce_sched: round-robin scheduler for one shared reduction/mean unit.
// Define REDUCE_SCHED_WATCHDOG_EN to add a WAIT-state timeout response.
module reduce_sched
    import reduce_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_ptr,
    input  logic [32*NUM_REQ-1:0] req_params,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [31:0]           rsp_result,
    output logic                  rsp_error,
    output logic                  unit_start,
    output logic [31:0]           unit_ptr,
    output logic [31:0]           unit_params,
    input  logic                  unit_ready,
    input  logic                  unit_done,
    input  logic [31:0]           unit_result,
    output logic [IW-1:0]         grant_id,
    output logic                  busy
);

    state_e               state;
    state_e               state_nx;
    logic [IW-1:0]        rr_ptr;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [IW-1:0]        arb_idx;
    logic                 arb_any;
    logic                 accept;
    logic                 rsp_hs;
    logic                 wd_expire;
    logic [31:0]          sel_ptr;
    logic [31:0]          sel_params;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign accept = (state == S_IDLE) && arb_any && unit_ready;
    assign rsp_hs = (state == S_RESP) && rsp_ready[grant_id];

    always_comb begin
        sel_ptr    = '0;
        sel_params = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_ptr    = req_ptr[32*i +: 32];
                sel_params = req_params[32*i +: 32];
            end
        end
    end

`ifdef REDUCE_SCHED_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] wd_cnt;
    logic          err_q;

    // done in the expiry cycle wins, so expiry requires !unit_done
    assign wd_expire = (state == S_WAIT) && !unit_done &&
                       (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == S_WAIT) wd_cnt <= wd_cnt + CW'(1);
            else                 wd_cnt <= '0;
            if (state == S_WAIT && unit_done) err_q <= 1'b0;
            else if (wd_expire)               err_q <= 1'b1;
        end
    end

    assign rsp_error = err_q;
`else
    assign wd_expire = 1'b0;
    assign rsp_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (accept) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (unit_done || wd_expire) state_nx = S_RESP;
            S_RESP:  if (rsp_hs) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = accept ? arb_grant : '0;
        unit_start = (state == S_ISSUE);
        rsp_valid  = '0;
        if (state == S_RESP) rsp_valid[grant_id] = 1'b1;
        busy       = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            grant_id    <= '0;
            unit_ptr    <= '0;
            unit_params <= '0;
            rsp_result  <= '0;
        end else begin
            if (accept) begin
                grant_id    <= arb_idx;
                unit_ptr    <= sel_ptr;
                unit_params <= {sel_params[DIMS_MSB:DIMS_LSB],
                                sel_params[AXES_MSB:AXES_LSB]};
            end
            if (state == S_WAIT && unit_done) rsp_result <= unit_result;
            else if (wd_expire)               rsp_result <= '0;
            if (rsp_hs) begin
                rr_ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0
                                                         : grant_id + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_reduce_sched.sv
// tb_reduce_sched: directed table plus hand sequences for reduce_sched.
// Watchdog sequence runs only when REDUCE_SCHED_WATCHDOG_EN is defined.
module tb_reduce_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_ptr;
    logic [127:0] req_params;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready;
    logic [31:0]  rsp_result;
    logic         rsp_error;
    logic         unit_start;
    logic [31:0]  unit_ptr;
    logic [31:0]  unit_params;
    logic         unit_ready;
    logic         unit_done;
    logic [31:0]  unit_result;
    logic [1:0]   grant_id;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  req;
        int          g;
        int          lat;
        logic [31:0] res;
    } vec_t;

    vec_t tbl [9];

    reduce_sched #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_ptr     (req_ptr),
        .req_params  (req_params),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_error   (rsp_error),
        .unit_start  (unit_start),
        .unit_ptr    (unit_ptr),
        .unit_params (unit_params),
        .unit_ready  (unit_ready),
        .unit_done   (unit_done),
        .unit_result (unit_result),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // from the negedge of the accept cycle through the rsp handshake
    task automatic finish_op(input int g, input int lat,
                             input logic [31:0] res);
        logic [3:0] oh;
        oh = 4'b0001 << g;
        @(posedge clk); #1 req_valid = 4'b0000;
        @(negedge clk);
        chk("unit_start", 32'(unit_start), 32'd1);
        chk("grant_id", 32'(grant_id), g);
        chk("unit_ptr", unit_ptr, 32'h1000 * (g + 1));
        chk("unit_params", unit_params, 32'h00020001 + g);
        chk("req_ready_issue", 32'(req_ready), 32'd0);
        repeat (lat + 1) @(posedge clk);
        #1 unit_done = 1'b1; unit_result = res;
        @(negedge clk);
        chk("rsp_valid_early", 32'(rsp_valid), 32'd0);
        chk("unit_start_wait", 32'(unit_start), 32'd0);
        @(posedge clk); #1 unit_done = 1'b0; rsp_ready = 4'b1111;
        @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid), 32'(oh));
        chk("rsp_result", rsp_result, res);
        chk("rsp_error", 32'(rsp_error), 32'd0);
        @(posedge clk); #1 rsp_ready = 4'b0000;
        @(negedge clk);
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic wait_accept();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) break;
        end
    endtask

    task automatic run_op(input logic [3:0] rv, input int g, input int lat,
                          input logic [31:0] res);
        @(posedge clk); #1 req_valid = rv;
        wait_accept();
        chk("req_ready", 32'(req_ready), 32'(4'b0001 << g));
        finish_op(g, lat, res);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{4'b0001, 0, 4, 32'h0000_0001};
        tbl[1] = '{4'b1111, 1, 0, 32'h0000_00a1};
        tbl[2] = '{4'b1111, 2, 1, 32'h0000_00a2};
        tbl[3] = '{4'b1111, 3, 2, 32'h0000_00a3};
        tbl[4] = '{4'b1111, 0, 0, 32'h0000_00a4};
        tbl[5] = '{4'b0101, 2, 3, 32'hdead_0005};
        tbl[6] = '{4'b0011, 0, 0, 32'hdead_0006};
        tbl[7] = '{4'b1000, 3, 1, 32'hdead_0007};
        tbl[8] = '{4'b0110, 1, 0, 32'hdead_0008};

        for (int i = 0; i < 4; i++) begin
            req_ptr[32*i +: 32]    = 32'h1000 * (i + 1);
            req_params[32*i +: 32] = 32'h00020001 + i;
        end
        rst_n       = 1'b0;
        req_valid   = '0;
        rsp_ready   = '0;
        unit_ready  = 1'b1;
        unit_done   = 1'b0;
        unit_result = '0;

        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_unit_start", 32'(unit_start), 32'd0);
        chk("rst_unit_ptr", unit_ptr, 32'd0);
        chk("rst_unit_params", unit_params, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_op(tbl[i].req, tbl[i].g, tbl[i].lat, tbl[i].res);

        // requester 2 stalls its response; others' rsp_ready is ignored
        @(posedge clk); #1 req_valid = 4'b1111;
        wait_accept();
        chk("stall_req_ready", 32'(req_ready), 32'b0100);
        @(posedge clk);
        @(posedge clk); #1 unit_done = 1'b1; unit_result = 32'h0000_beef;
        @(posedge clk); #1 unit_done = 1'b0; rsp_ready = 4'b1011;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'b0100);
            chk("stall_result", rsp_result, 32'h0000_beef);
            chk("stall_req_ready0", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 4'b1111;
        @(negedge clk);
        chk("stall_hs_valid", 32'(rsp_valid), 32'b0100);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_req_ready", 32'(req_ready), 32'b1000);
        @(posedge clk); #1 req_valid = 4'b0000; rsp_ready = 4'b0000;
        @(negedge clk);
        chk("b2b_unit_start", 32'(unit_start), 32'd1);

        // asynchronous reset during WAIT
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_unit_start", 32'(unit_start), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_grant_id", 32'(grant_id), 32'd0);
        chk("mid_rst_unit_ptr", unit_ptr, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // unit not ready: requests wait, then rr_ptr=0 picks requester 0
        @(posedge clk); #1 unit_ready = 1'b0; req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("nur_req_ready", 32'(req_ready), 32'd0);
            chk("nur_unit_start", 32'(unit_start), 32'd0);
            chk("nur_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
        end
        unit_ready = 1'b1;
        @(negedge clk);
        chk("nur_grant", 32'(req_ready), 32'b0001);
        finish_op(0, 2, 32'h1234_5678);

        // unit_done while idle must not move the FSM
        @(posedge clk); #1 unit_done = 1'b1; unit_result = 32'hffff_ffff;
        @(negedge clk);
        chk("stray_done_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 unit_done = 1'b0;
        @(negedge clk);
        chk("stray_done_busy2", 32'(busy), 32'd0);
        chk("stray_done_rsp", 32'(rsp_valid), 32'd0);

        // rr_ptr is 1 here, so 0011 grants requester 1
        run_op(4'b0011, 1, 0, 32'h0000_0042);

`ifdef REDUCE_SCHED_WATCHDOG_EN
        @(posedge clk); #1 req_valid = 4'b0001;
        wait_accept();
        chk("wd_req_ready", 32'(req_ready), 32'b0001);
        @(posedge clk); #1 req_valid = 4'b0000;
        repeat (16) @(posedge clk);
        @(negedge clk);
        chk("wd_not_yet", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("wd_rsp_valid", 32'(rsp_valid), 32'b0001);
        chk("wd_rsp_error", 32'(rsp_error), 32'd1);
        chk("wd_rsp_result", rsp_result, 32'd0);
        @(posedge clk); #1 rsp_ready = 4'b0001;
        @(posedge clk); #1 rsp_ready = 4'b0000;
        @(negedge clk);
        chk("wd_busy_after", 32'(busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reduce_sched.md
# reduce_sched

Round-robin scheduler sharing one reduction/mean unit among NUM_REQ requesters (vision-model softcore ops: mean, sum-pool, global average). It accepts one request at a time and drives the unit's start/ready/done handshake. It returns the 32-bit result to the granted requester and holds it until that requester accepts it. It sits between the op dispatcher ports and the reduction datapath.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- TIMEOUT_CYCLES, default 1024: watchdog limit in the WAIT state (used only with the watchdog macro defined).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset: asynchronous and active-low.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- req_ptr  in  32*NUM_REQ  packed input pointers; slice i = bits [32*i+31:32*i].
- req_params  in  32*NUM_REQ  packed params, [31:16] dims, [15:0] axes.
- rsp_valid  out  NUM_REQ  one-hot response valid.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_result  out  32  result for the granted requester.
- rsp_error  out  1  response is a timeout, not a result.
- unit_start  out  1  one-cycle start pulse to the unit.
- unit_ptr  out  32  latched pointer.
- unit_params  out  32  latched params.
- unit_ready  in  1  unit idle.
- unit_done  in  1  unit result valid, one cycle.
- unit_result  in  32  unit result.
- grant_id  out  max(1,$clog2(NUM_REQ))  current/last grantee.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE -> ISSUE when |req_valid && unit_ready:
  - Arbiter picks the first asserted req_valid at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[g] pulses for that cycle.
  - ptr, params and grant_id are latched.
- ISSUE:
  - unit_start=1 for exactly one cycle.
  - unit_ptr/unit_params hold the latched values from ISSUE through RESP.
  - Next state is WAIT.
- WAIT: on unit_done, capture unit_result and set rsp_error=0; next state is RESP.
- RESP:
  - rsp_valid[grant_id]=1 until rsp_ready[grant_id].
  - rsp_ready on other bits is ignored.
  - On handshake: rr_ptr = (grant_id+1) mod NUM_REQ, then go to IDLE.
- unit_done outside WAIT is ignored.
- A requester that drops req_valid before grant is simply skipped. Dropping after grant has no effect; its request is already latched.
- Requests are never queued: at most one outstanding operation.

## Timing
- Reset values:
  - All outputs 0; grant_id 0.
  - rr_ptr 0, state IDLE.
  - Watchdog counter 0.
- Reset asserted mid-operation:
  - Immediately clears unit_start and rsp_valid.
  - The unit is not drained; the dispatcher re-issues the request.
- Accept at cycle T (req_ready high).
- unit_start at T+1.
- WAIT from T+2.
- If unit_done arrives at cycle D, rsp_valid is asserted at D+1.
- Minimum request-to-response latency: 3 cycles plus unit latency.
- Back-to-back: the earliest next accept is the cycle after the rsp handshake.
- If unit_ready is low in IDLE, no grant is made and requests wait.

## Configuration
- REDUCE_SCHED_WATCHDOG_EN defined:
  - A WAIT-state counter increments each cycle.
  - When the count reaches TIMEOUT_CYCLES-1 without unit_done, go to RESP with rsp_result=0 and rsp_error=1.
  - unit_done in the same cycle as expiry wins, giving a normal result.
- Undefined:
  - No counter; WAIT holds until unit_done.
  - rsp_error is tied 0.

## Structure
- reduce_sched_pkg:
  - State enum.
  - Param field constants DIMS_MSB=31, DIMS_LSB=16, AXES_MSB=15, AXES_LSB=0.
  - Default TIMEOUT_CYCLES.
- Sub-module rr_arbiter (NUM_REQ):
  - Combinational pick from the request vector and rr_ptr.
  - Outputs one-hot grant, encoded index and any-valid.
  - rr_ptr register lives in the top.

## Test plan
- Single request: req_valid=0001, ptr=0x1000, params=0x00020001; unit_done 5 cycles after start with result 0x00000001 -> unit_start at T+1, unit_ptr=0x1000, rsp_valid=0001, rsp_result=1, rsp_error=0.
- All four requesting continuously, immediate rsp_ready -> grant order 0,1,2,3,0; each requester is granted once per four operations.
- Requester 2 holds rsp_ready low for 10 cycles -> rsp_valid=0100 and result remain stable; no new req_ready pulses.
- unit_ready=0 with req_valid=1111 -> no grant and no start until unit_ready rises; then requester 0 (rr_ptr=0) is granted.
- Watchdog enabled, TIMEOUT_CYCLES=16, unit never responds -> rsp_valid after 16 WAIT cycles with rsp_error=1 and rsp_result=0.
- rst_n pulled low during WAIT -> all outputs 0 asynchronously; after release busy=0; the next request is serviced normally starting from requester 0.
